// File: rtl/promedio_adc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : promedio_adc_pkg
// Brief    : Shared types and frame-format constants for the ADC averager.
// Revision : 1.0 - initial release
// ============================================================================
package promedio_adc_pkg;

  // Averager control states
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    ACUM = 1'b1
  } estado_t;

  // ADC frame layout: 16-bit word, 4-bit header that must read zero
  localparam int          ANCHO_TRAMA = 16;
  localparam int          CAB_MSB     = 15;
  localparam int          CAB_LSB     = 12;
  localparam logic [3:0]  CAB_VALOR   = 4'b0000;

  // Default sample width
  localparam int          ANCHO_DEF   = 12;

endpackage : promedio_adc_pkg
`default_nettype wire

// File: rtl/promedio_adc_detector_flanco.sv
`default_nettype none
// ============================================================================
// Module   : detector_flanco
// Brief    : Rising-edge detector. The delayed copy resets to 1 so a signal
//            already high when reset is released is not seen as an edge.
// Revision : 1.0 - initial release
// ============================================================================
module detector_flanco (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_senal,
  output logic o_flanco
);

  logic r_senal_q;

  // One-cycle delayed copy of the input
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_senal_q <= 1'b1;
    else       r_senal_q <= i_senal;
  end

  assign o_flanco = i_senal & ~r_senal_q;

endmodule : detector_flanco
`default_nettype wire

// File: rtl/promedio_adc.sv
`default_nettype none
// ============================================================================
// Module   : promedio_adc
// Brief    : Validates ADC frames on CS rising edge, keeps a moving average
//            of the last 2^LOG2_N samples and offers it via valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
module promedio_adc
  import promedio_adc_pkg::*;
#(
  parameter int LOG2_N = 2,
  parameter int ANCHO  = ANCHO_DEF
) (
  input  logic                   CLK1MHz,
  input  logic                   Reset,
  input  logic                   CS,
  input  logic [ANCHO_TRAMA-1:0] DoutParalelo,
  output logic [ANCHO-1:0]       Promedio,
  output logic                   Valido,
  input  logic                   Listo,
  output logic [ANCHO-1:0]       Muestra,
  output logic                   Sobrecarga,
  output logic                   ErrorTrama
);

  localparam int              N     = 1 << LOG2_N;
  localparam int              ASUMA = ANCHO + LOG2_N;
  localparam logic [LOG2_N:0] c_N   = (LOG2_N + 1)'(N);

  logic                w_flanco;
  logic                w_cab_ok;
  logic                w_trama_ok;
  logic                w_trama_mala;
  logic                w_en_acum;
  logic                w_resultado;
  logic [ASUMA-1:0]    w_suma_next;
  logic [LOG2_N:0]     w_llenado_next;

  estado_t             r_estado;
  logic                r_pending;
  logic [ANCHO-1:0]    r_captura;
  logic [ANCHO-1:0]    r_buffer [N];
  logic [ASUMA-1:0]    r_suma;
  logic [LOG2_N:0]     r_llenado;
  logic [LOG2_N-1:0]   r_puntero;

  detector_flanco u_detector_flanco (
    .i_clk    (CLK1MHz),
    .i_rst    (Reset),
    .i_senal  (CS),
    .o_flanco (w_flanco)
  );

  assign w_cab_ok     = (DoutParalelo[CAB_MSB:CAB_LSB] == CAB_VALOR);
  assign w_trama_ok   = w_flanco & w_cab_ok;
  assign w_trama_mala = w_flanco & ~w_cab_ok;
  assign w_en_acum    = (r_estado == ACUM);

  // The evicted entry is always part of the running sum, so this never wraps
  assign w_suma_next    = r_suma + ASUMA'(r_captura) - ASUMA'(r_buffer[r_puntero]);
  assign w_llenado_next = (r_llenado == c_N) ? r_llenado : r_llenado + (LOG2_N + 1)'(1);
  assign w_resultado    = w_en_acum && (w_llenado_next == c_N);

  // Capture a well-formed frame; a new edge during ACUM keeps the request alive
  always_ff @(posedge CLK1MHz or posedge Reset) begin
    if (Reset) begin
      r_pending  <= 1'b0;
      r_captura  <= '0;
      ErrorTrama <= 1'b0;
    end else begin
      ErrorTrama <= w_trama_mala;
      if (w_trama_ok) begin
        r_captura <= DoutParalelo[ANCHO-1:0];
        r_pending <= 1'b1;
      end else if (w_en_acum) begin
        r_pending <= 1'b0;
      end
    end
  end

  // Control: one ACUM cycle per pending sample
  always_ff @(posedge CLK1MHz or posedge Reset) begin
    if (Reset) begin
      r_estado <= IDLE;
    end else begin
      case (r_estado)
        IDLE:    if (r_pending) r_estado <= ACUM;
        ACUM:    r_estado <= IDLE;
        default: r_estado <= IDLE;
      endcase
    end
  end

  // Circular buffer, running sum, fill level and last sample
  always_ff @(posedge CLK1MHz or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < N; i++) r_buffer[i] <= '0;
      r_suma    <= '0;
      r_llenado <= '0;
      r_puntero <= '0;
      Muestra   <= '0;
    end else if (w_en_acum) begin
      r_buffer[r_puntero] <= r_captura;
      r_suma              <= w_suma_next;
      r_llenado           <= w_llenado_next;
      r_puntero           <= r_puntero + LOG2_N'(1);
      Muestra             <= r_captura;
    end
  end

  // Output hold register with valid/ready handshake and sticky overrun flag
  always_ff @(posedge CLK1MHz or posedge Reset) begin
    if (Reset) begin
      Promedio   <= '0;
      Valido     <= 1'b0;
      Sobrecarga <= 1'b0;
    end else if (w_resultado) begin
      Promedio <= w_suma_next[ASUMA-1:LOG2_N];
      Valido   <= 1'b1;
      if (Valido && !Listo) Sobrecarga <= 1'b1;
    end else if (Valido && Listo) begin
      Valido <= 1'b0;
    end
  end

endmodule : promedio_adc
`default_nettype wire

// File: tb/tb_promedio_adc.sv
`default_nettype none
// ============================================================================
// Module   : tb_promedio_adc
// Brief    : Directed self-checking bench for promedio_adc (LOG2_N = 2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_promedio_adc;

  logic        clk;
  logic        Reset;
  logic        CS;
  logic [15:0] Dout;
  logic [11:0] Promedio;
  logic        Valido;
  logic        Listo;
  logic [11:0] Muestra;
  logic        Sobrecarga;
  logic        ErrorTrama;

  int          vectores;
  int          errores;

  // reference model state
  logic [11:0] m_buf [4];
  int          m_sum;
  int          m_ptr;
  int          m_fill;
  logic        m_val;
  logic        m_sob;
  logic [11:0] m_prom;
  logic [11:0] m_mue;
  logic [11:0] q [$];

  promedio_adc #(
    .LOG2_N (2),
    .ANCHO  (12)
  ) dut (
    .CLK1MHz      (clk),
    .Reset        (Reset),
    .CS           (CS),
    .DoutParalelo (Dout),
    .Promedio     (Promedio),
    .Valido       (Valido),
    .Listo        (Listo),
    .Muestra      (Muestra),
    .Sobrecarga   (Sobrecarga),
    .ErrorTrama   (ErrorTrama)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectores++;
    assert (obs === exp) else begin
      errores++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_buf[i] = '0;
    m_sum  = 0;
    m_ptr  = 0;
    m_fill = 0;
    m_val  = 1'b0;
    m_sob  = 1'b0;
    m_prom = '0;
    m_mue  = '0;
    q.delete();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_prom"}, 32'(Promedio),   32'h0);
    chk({tag, "_val"},  32'(Valido),     32'h0);
    chk({tag, "_mue"},  32'(Muestra),    32'h0);
    chk({tag, "_sob"},  32'(Sobrecarga), 32'h0);
    chk({tag, "_err"},  32'(ErrorTrama), 32'h0);
  endtask

  // Send one frame; expectations from the model go through the queue
  task automatic frame(input logic [15:0] w, input logic listo);
    bit ok;
    bit res;
    @(negedge clk);
    CS    = 1'b0;
    Listo = listo;
    if (listo) m_val = 1'b0;
    repeat (3) @(negedge clk);
    Dout = w;
    CS   = 1'b1;
    ok   = (w[15:12] == 4'h0);
    res  = 1'b0;
    if (ok) begin
      m_sum = m_sum - int'(m_buf[m_ptr]) + int'(w[11:0]);
      m_buf[m_ptr] = w[11:0];
      m_ptr = (m_ptr + 1) % 4;
      if (m_fill < 4) m_fill++;
      if (m_fill == 4) begin
        q.push_back(12'(m_sum >> 2));
        res = 1'b1;
      end
    end
    @(posedge clk); #1;   // edge k
    chk("errtrama_k+1", 32'(ErrorTrama), 32'(!ok));
    @(posedge clk); #1;   // k+1
    chk("errtrama_k+2", 32'(ErrorTrama), 32'h0);
    @(posedge clk); #1;   // k+2
    if (res) begin
      if (m_val && !listo) m_sob = 1'b1;
      m_val  = 1'b1;
      m_prom = q.pop_front();
    end
    if (ok) m_mue = w[11:0];
    chk("promedio",   32'(Promedio),   32'(m_prom));
    chk("valido",     32'(Valido),     32'(m_val));
    chk("muestra",    32'(Muestra),    32'(m_mue));
    chk("sobrecarga", 32'(Sobrecarga), 32'(m_sob));
    @(posedge clk); #1;   // k+3
    if (listo) m_val = 1'b0;
    chk("valido_k+3",   32'(Valido),   32'(m_val));
    chk("promedio_k+3", 32'(Promedio), 32'(m_prom));
    repeat (10) @(posedge clk);
  endtask

  initial begin
    vectores = 0;
    errores  = 0;
    model_reset();
    Reset = 1'b1;
    CS    = 1'b1;
    Dout  = 16'h0000;
    Listo = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("in_reset");

    // Release reset with CS already high: no edge may be seen
    @(negedge clk);
    Reset = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("cs_high_err", 32'(ErrorTrama), 32'h0);
      chk("cs_high_val", 32'(Valido),     32'h0);
      chk("cs_high_mue", 32'(Muestra),    32'h0);
    end

    // Warm-up and first average
    frame(16'h0010, 1'b1);
    frame(16'h0020, 1'b1);
    frame(16'h0030, 1'b1);
    frame(16'h0040, 1'b1);
    // Pointer wrap, oldest entry evicted
    frame(16'h0050, 1'b1);
    // Bad header: dropped, one-cycle error pulse
    frame(16'hA123, 1'b1);
    frame(16'h0060, 1'b1);

    // Unconsumed result overwritten -> sticky overrun
    frame(16'h0070, 1'b0);
    frame(16'h0080, 1'b0);
    frame(16'h0090, 1'b1);
    frame(16'h0FFF, 1'b1);

    // Asynchronous reset while the FSM sits in ACUM
    @(negedge clk);
    CS = 1'b0;
    repeat (3) @(negedge clk);
    Dout = 16'h0011;
    CS   = 1'b1;
    @(posedge clk);       // edge k
    @(posedge clk);       // k+1, now in ACUM
    #2;
    Reset = 1'b1;
    #1;
    chk_all_zero("async_reset");
    model_reset();
    @(negedge clk);
    Reset = 1'b0;
    repeat (5) @(negedge clk);
    chk_all_zero("after_reset");

    frame(16'h0100, 1'b1);
    frame(16'h0200, 1'b1);
    frame(16'h0300, 1'b1);
    frame(16'h0400, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectores, errores);
    $finish;
  end

endmodule : tb_promedio_adc
`default_nettype wire
